// File: rtl/ahb_ram_ctrl.sv
// AHB-Lite slave in front of a single-port banked SRAM (BLOCKS x 1K x 32).
// Reads are zero-wait, and writes commit in the data phase. A read that collides with a write data phase costs one stall.
module ahb_ram_ctrl #(
  parameter int BLOCKS = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA,
  output logic        ram_EN,
  output logic [3:0]  ram_WE,
  output logic [12:0] ram_A,
  output logic [31:0] ram_Di,
  input  logic [31:0] ram_Do
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_STALL, S_ERR1, S_ERR2} state_t;

  state_t      state_q, state_d;
  logic [12:0] addr_q, addr_d;
  logic [3:0]  mask_q, mask_d;

  logic       acc, conflict, err, do_acc;
  logic [3:0] mask;
  logic       unused_ok;

  assign unused_ok = ^{HADDR[31:15], HTRANS[0]};

  assign acc      = HSEL & HTRANS[1] & HREADY;
  assign conflict = HSEL & HTRANS[1] & ~HWRITE;
  assign err      = ({1'b0, HADDR[14:12]} >= 4'(BLOCKS)) | (HSIZE >= 3'd3);

  always_comb begin
    case (HSIZE)
      3'd0:    mask = 4'b0001 << HADDR[1:0];
      3'd1:    mask = HADDR[1] ? 4'b1100 : 4'b0011;
      default: mask = 4'b1111;
    endcase
  end

  // Kept apart from the main comb block so HREADYOUT never depends on HREADY.
  assign HREADYOUT = !((state_q == S_ERR1) || ((state_q == S_WR) && conflict));
  assign HRESP     = (state_q == S_ERR1) || (state_q == S_ERR2);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    mask_d  = mask_q;
    HRDATA  = '0;
    ram_EN  = 1'b0;
    ram_WE  = 4'b0000;
    ram_A   = HADDR[14:2];
    ram_Di  = '0;
    do_acc  = 1'b0;

    case (state_q)
      S_WR: begin
        ram_EN = 1'b1;
        ram_WE = mask_q;
        ram_A  = addr_q;
        ram_Di = HWDATA;
        if (conflict) state_d = S_STALL;
        else          do_acc  = 1'b1;
      end
      S_ERR1:  state_d = S_ERR2;
      S_RD: begin
        HRDATA = ram_Do;
        do_acc = 1'b1;
      end
      default: do_acc = 1'b1;
    endcase

    if (do_acc) begin
      state_d = S_IDLE;
      if (acc) begin
        if (err) begin
          state_d = S_ERR1;
        end else if (HWRITE) begin
          addr_d  = HADDR[14:2];
          mask_d  = mask;
          state_d = S_WR;
        end else begin
          ram_EN  = 1'b1;
          ram_WE  = 4'b0000;
          ram_A   = HADDR[14:2];
          state_d = S_RD;
        end
      end
    end

    // Keep the macro quiet for the whole reset window, including a dropped write.
    if (RST) begin
      ram_EN = 1'b0;
      ram_WE = 4'b0000;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
    end
  end

endmodule

// File: tb/tb_ahb_ram_ctrl.sv
// Directed bench for ahb_ram_ctrl with a behavioural 4K x 32 SRAM model.
module tb_ahb_ram_ctrl;
  logic        CLK = 1'b0;
  logic        RST;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic        ram_EN;
  logic [3:0]  ram_WE;
  logic [12:0] ram_A;
  logic [31:0] ram_Di;
  logic [31:0] ram_Do;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mem [0:4095];

  ahb_ram_ctrl #(.BLOCKS(4)) dut (
    .CLK(CLK), .RST(RST), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
    .ram_EN(ram_EN), .ram_WE(ram_WE), .ram_A(ram_A), .ram_Di(ram_Di), .ram_Do(ram_Do)
  );

  always #5 CLK = ~CLK;
  assign HREADY = HREADYOUT;

  // SRAM model: byte-enabled write, registered read on enabled non-write edges.
  always @(posedge CLK) begin
    if (ram_EN) begin
      if (ram_WE != 4'b0000) begin
        for (int b = 0; b < 4; b++)
          if (ram_WE[b]) mem[ram_A[11:0]][8*b +: 8] <= ram_Di[8*b +: 8];
      end else begin
        ram_Do <= mem[ram_A[11:0]];
      end
    end
  end

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic sample();
    @(negedge CLK);
  endtask

  task automatic idle_bus();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = '0; HSIZE = 3'd2;
  endtask

  task automatic wr_phase(input logic [31:0] a, input logic [2:0] sz);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a; HSIZE = sz;
  endtask

  task automatic rd_phase(input logic [31:0] a, input logic [2:0] sz);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a; HSIZE = sz;
  endtask

  task automatic test_reset();
    RST = 1'b1; HWDATA = '0; idle_bus();
    step(); rd_phase(32'h10, 3'd2); sample();
    n_cmp++; if (HREADYOUT !== 1'b1) begin n_err++; $display("FAIL rst_hready got %b want 1", HREADYOUT); end
    n_cmp++; if (HRESP !== 1'b0) begin n_err++; $display("FAIL rst_hresp got %b want 0", HRESP); end
    n_cmp++; if (HRDATA !== 32'h0) begin n_err++; $display("FAIL rst_hrdata got %h want 0", HRDATA); end
    n_cmp++; if (ram_EN !== 1'b0) begin n_err++; $display("FAIL rst_en got %b want 0", ram_EN); end
    n_cmp++; if (ram_WE !== 4'h0) begin n_err++; $display("FAIL rst_we got %b want 0000", ram_WE); end
    idle_bus(); RST = 1'b0;
  endtask

  task automatic test_word_rw();
    step(); wr_phase(32'h10, 3'd2); sample();
    n_cmp++; if (HREADYOUT !== 1'b1) begin n_err++; $display("FAIL wr_addr_hready got %b want 1", HREADYOUT); end
    n_cmp++; if (ram_EN !== 1'b0) begin n_err++; $display("FAIL wr_addr_en got %b want 0", ram_EN); end
    step(); HWDATA = 32'hDEADBEEF; rd_phase(32'h10, 3'd2); sample();
    n_cmp++; if (HREADYOUT !== 1'b0) begin n_err++; $display("FAIL wr_conflict_hready got %b want 0", HREADYOUT); end
    n_cmp++; if (ram_WE !== 4'hF) begin n_err++; $display("FAIL wr_we got %b want 1111", ram_WE); end
    n_cmp++; if (ram_A !== 13'd4) begin n_err++; $display("FAIL wr_a got %h want 4", ram_A); end
    n_cmp++; if (ram_Di !== 32'hDEADBEEF) begin n_err++; $display("FAIL wr_di got %h want deadbeef", ram_Di); end
    step(); sample();
    n_cmp++; if (HREADYOUT !== 1'b1) begin n_err++; $display("FAIL stall_hready got %b want 1", HREADYOUT); end
    n_cmp++; if ({ram_EN, ram_WE} !== 5'b10000) begin n_err++; $display("FAIL stall_rd got en=%b we=%b want en=1 we=0000", ram_EN, ram_WE); end
    step(); idle_bus(); sample();
    n_cmp++; if (HRDATA !== 32'hDEADBEEF) begin n_err++; $display("FAIL word_rd got %h want deadbeef", HRDATA); end
    step(); sample();
    n_cmp++; if (HRDATA !== 32'h0) begin n_err++; $display("FAIL idle_hrdata got %h want 0", HRDATA); end
  endtask

  task automatic test_byte_half();
    step(); wr_phase(32'h21, 3'd0); sample();
    step(); HWDATA = 32'h0000_1100; wr_phase(32'h22, 3'd1); sample();
    n_cmp++; if (ram_WE !== 4'b0010) begin n_err++; $display("FAIL byte_we got %b want 0010", ram_WE); end
    n_cmp++; if (HREADYOUT !== 1'b1) begin n_err++; $display("FAIL b2b_wr_hready got %b want 1", HREADYOUT); end
    step(); HWDATA = 32'hAABB_0000; rd_phase(32'h20, 3'd2); sample();
    n_cmp++; if (ram_WE !== 4'b1100) begin n_err++; $display("FAIL half_we got %b want 1100", ram_WE); end
    step(); sample();
    step(); idle_bus(); sample();
    n_cmp++; if (HRDATA !== 32'hAABB1100) begin n_err++; $display("FAIL byte_half_rd got %h want aabb1100", HRDATA); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d [4];
    int stalls;
    d = '{32'hA0A0_0001, 32'hB1B1_0002, 32'hC2C2_0003, 32'hD3D3_0004};
    stalls = 0;
    step(); wr_phase(32'h100, 3'd2); sample();
    if (!HREADYOUT) stalls++;
    for (int i = 1; i < 4; i++) begin
      step(); HWDATA = d[i-1]; wr_phase(32'h100 + 32'(4*i), 3'd2); sample();
      if (!HREADYOUT) stalls++;
      n_cmp++; if (ram_A !== 13'(64 + i - 1)) begin n_err++; $display("FAIL b2b_wr_a%0d got %h want %h", i, ram_A, 13'(64 + i - 1)); end
    end
    step(); HWDATA = d[3]; rd_phase(32'h100, 3'd2); sample();
    if (!HREADYOUT) stalls++;
    n_cmp++; if (ram_A !== 13'd67) begin n_err++; $display("FAIL b2b_wr_a3 got %h want 43", ram_A); end
    step(); sample();
    if (!HREADYOUT) stalls++;
    for (int i = 0; i < 4; i++) begin
      step();
      if (i < 3) rd_phase(32'h104 + 32'(4*i), 3'd2); else idle_bus();
      sample();
      if (!HREADYOUT) stalls++;
      n_cmp++; if (HRDATA !== d[i]) begin n_err++; $display("FAIL b2b_rd%0d got %h want %h", i, HRDATA, d[i]); end
    end
    n_cmp++; if (stalls !== 1) begin n_err++; $display("FAIL b2b_stalls got %0d want 1", stalls); end
  endtask

  task automatic test_error();
    step(); rd_phase(32'h3FFC, 3'd2); sample();
    n_cmp++; if (ram_EN !== 1'b1) begin n_err++; $display("FAIL last_bank_en got %b want 1", ram_EN); end
    step(); idle_bus(); sample();
    n_cmp++; if ({HREADYOUT, HRESP} !== 2'b10) begin n_err++; $display("FAIL last_bank_resp got %b want 10", {HREADYOUT, HRESP}); end
    step(); rd_phase(32'h4000, 3'd2); sample();
    n_cmp++; if (ram_EN !== 1'b0) begin n_err++; $display("FAIL oob_addr_en got %b want 0", ram_EN); end
    step(); idle_bus(); sample();
    n_cmp++; if ({HREADYOUT, HRESP, ram_EN} !== 3'b010) begin n_err++; $display("FAIL oob_err1 got %b want 010", {HREADYOUT, HRESP, ram_EN}); end
    step(); sample();
    n_cmp++; if ({HREADYOUT, HRESP, ram_EN} !== 3'b110) begin n_err++; $display("FAIL oob_err2 got %b want 110", {HREADYOUT, HRESP, ram_EN}); end
    step(); sample();
    n_cmp++; if (HRESP !== 1'b0) begin n_err++; $display("FAIL oob_done got %b want 0", HRESP); end
    step(); wr_phase(32'h10, 3'd3); sample();
    step(); HWDATA = 32'h1234_5678; idle_bus(); sample();
    n_cmp++; if ({HREADYOUT, HRESP, ram_EN, ram_WE} !== 7'b0100000) begin n_err++; $display("FAIL size3_err1 got %b want 0100000", {HREADYOUT, HRESP, ram_EN, ram_WE}); end
    step(); rd_phase(32'h10, 3'd2); sample();
    n_cmp++; if ({HREADYOUT, HRESP, ram_EN} !== 3'b111) begin n_err++; $display("FAIL err2_accept got %b want 111", {HREADYOUT, HRESP, ram_EN}); end
    step(); idle_bus(); sample();
    n_cmp++; if (HRDATA !== 32'hDEADBEEF) begin n_err++; $display("FAIL size3_unchanged got %h want deadbeef", HRDATA); end
  endtask

  task automatic test_reset_mid_write();
    step(); wr_phase(32'h40, 3'd2); sample();
    step(); HWDATA = 32'h5555_AAAA; idle_bus(); sample();
    step(); wr_phase(32'h40, 3'd2); sample();
    step(); HWDATA = 32'hCAFE_F00D; idle_bus(); #1;
    n_cmp++; if (ram_WE !== 4'hF) begin n_err++; $display("FAIL pre_rst_we got %b want 1111", ram_WE); end
    RST = 1'b1; #1;
    n_cmp++; if ({ram_EN, ram_WE} !== 5'b0) begin n_err++; $display("FAIL rst_async_we got en=%b we=%b want 0", ram_EN, ram_WE); end
    n_cmp++; if ({HREADYOUT, HRESP} !== 2'b10) begin n_err++; $display("FAIL rst_async_resp got %b want 10", {HREADYOUT, HRESP}); end
    n_cmp++; if (HRDATA !== 32'h0) begin n_err++; $display("FAIL rst_async_hrdata got %h want 0", HRDATA); end
    sample(); step(); sample(); RST = 1'b0;
    step(); rd_phase(32'h40, 3'd2); sample();
    step(); idle_bus(); sample();
    n_cmp++; if (HRDATA !== 32'h5555AAAA) begin n_err++; $display("FAIL rst_dropped_wr got %h want 5555aaaa", HRDATA); end
  endtask

  task automatic test_idle_busy();
    logic [1:0] tr [3];
    logic       sel [3];
    tr  = '{2'b00, 2'b01, 2'b10};
    sel = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      step(); rd_phase(32'h10, 3'd2); HTRANS = tr[i]; HSEL = sel[i]; sample();
      n_cmp++; if ({HREADYOUT, HRESP, ram_EN} !== 3'b100) begin n_err++; $display("FAIL idle_busy%0d got %b want 100", i, {HREADYOUT, HRESP, ram_EN}); end
    end
    step(); idle_bus(); sample();
    n_cmp++; if ({HREADYOUT, HRESP, HRDATA} !== {2'b10, 32'h0}) begin n_err++; $display("FAIL idle_busy_after got %b/%h want 10/0", {HREADYOUT, HRESP}, HRDATA); end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    ram_Do = '0;
    test_reset();
    test_word_rw();
    test_byte_half();
    test_back_to_back();
    test_error();
    test_reset_mid_write();
    test_idle_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
